pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Match-level sequencer for the Pong game. It sits between the game-start strobe (UART receive data-valid), the frame timing (VSync-derived frame tick) and the ball/paddle datapath. It decides when the ball is held at centre, when play runs, who serves, and the running score. A match ends when one player reaches the score limit.

## Interface
Parameters:
- SCORE_WIDTH, 4, width of each score counter.
- SCORE_LIMIT, 9, points needed to win; legal range 1 to 2^SCORE_WIDTH-1.
- SERVE_FRAMES, 60, frame ticks the ball is held before each serve; legal range 1 to 255 (0 behaves as 1).

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock).
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Game_Start  in  1  single-cycle start strobe.
- i_Frame_Tick  in  1  single-cycle pulse, once per frame.
- i_Miss_P1  in  1  single-cycle pulse: ball passed the P1 (left) paddle.
- i_Miss_P2  in  1  single-cycle pulse: ball passed the P2 (right) paddle.
- o_State  out  3  state encoding: IDLE=0, SERVE=1, RUNNING=2, POINT=3, GAME_OVER=4.
- o_Play_Enable  out  1  ball and paddles may move; high only in RUNNING.
- o_Ball_Reset  out  1  hold the ball at centre; high in every state except RUNNING.
- o_Serve_Dir  out  1  direction of the next or current serve: 0 = toward P1, 1 = toward P2.
- o_Score_P1  out  SCORE_WIDTH  P1 points.
- o_Score_P2  out  SCORE_WIDTH  P2 points.
- o_Point  out  1  one-cycle pulse, high while in POINT.
- o_Winner  out  1  match winner (0 = P1, 1 = P2); valid only in GAME_OVER.

## Operation
- All outputs are Moore outputs decoded from registered state and registers; there are no input-to-output combinational paths.
- Reset values:
  - State is IDLE.
  - Scores are 0.
  - o_Winner = 0 and o_Serve_Dir = 1.
  - The frame counter is 0.
  - o_Play_Enable = 0, o_Ball_Reset = 1, o_Point = 0.
- IDLE:
  - i_Game_Start clears both scores, sets o_Serve_Dir = 1 and clears the frame counter, then moves to SERVE.
  - All other inputs are ignored.
- SERVE:
  - The frame counter (8 bits) increments on each i_Frame_Tick.
  - On a tick that arrives while the counter equals SERVE_FRAMES-1, the block moves to RUNNING and clears the counter.
- RUNNING, on a miss:
  - i_Miss_P1 alone gives P2 a point. o_Serve_Dir is set to 0, so the next serve goes toward the player who lost the point. Move to POINT.
  - i_Miss_P2 alone gives P1 a point. o_Serve_Dir is set to 1. Move to POINT.
  - Both misses in the same cycle: no score change, o_Serve_Dir is unchanged, move to SERVE (re-serve).
- POINT lasts exactly one cycle:
  - If the scoring player's score now equals SCORE_LIMIT, latch o_Winner and move to GAME_OVER.
  - Otherwise clear the frame counter and move to SERVE.
- GAME_OVER:
  - Scores and winner hold.
  - i_Game_Start clears scores, clears o_Winner, sets o_Serve_Dir = 1, clears the counter and moves to SERVE.
- Ignored inputs:
  - i_Game_Start is ignored in SERVE, RUNNING and POINT.
  - Miss pulses are ignored outside RUNNING.
  - i_Frame_Tick is ignored outside SERVE.
- Score arithmetic is unsigned and can never exceed SCORE_LIMIT, so it never wraps.
- Asserting reset mid-match returns immediately (asynchronously) to the reset values. The match is lost.

## Timing
- Start strobe at edge N: SERVE and cleared scores are visible after edge N; o_State = 1 in cycle N+1.
- Serve hold: RUNNING begins the cycle after the SERVE_FRAMES-th tick counted in SERVE. o_Play_Enable rises and o_Ball_Reset falls in that same cycle.
- Miss sampled at edge N:
  - Cycle N+1: score updated, o_State = POINT, o_Point = 1, o_Ball_Reset = 1, o_Play_Enable = 0.
  - Cycle N+2: SERVE or GAME_OVER.
- A frame tick coincident with entry into SERVE is not counted; counting starts the cycle after entry.
- Miss-to-ball-reset latency: 1 cycle.
- Winner-visible latency: 2 cycles after the final miss.

## Test plan
- Reset then idle:
  - Assert i_Rst_L=0 mid-RUNNING with scores 3/2 → o_State=0, scores 0/0, o_Ball_Reset=1, o_Play_Enable=0, o_Serve_Dir=1, all immediately, without a clock.
  - Ticks and misses while in IDLE → no change.
- Serve timing:
  - SERVE_FRAMES=3, start pulse, then 3 ticks spaced 10 cycles apart → RUNNING exactly 1 cycle after the 3rd tick, not earlier.
  - A tick on the SERVE entry cycle is not counted.
- Scoring:
  - In RUNNING, pulse i_Miss_P1 → next cycle POINT with o_Point=1, o_Score_P2=1, o_Serve_Dir=0.
  - One cycle later o_State=SERVE.
  - Repeat with i_Miss_P2 → o_Score_P1=1, o_Serve_Dir=1.
- Match end:
  - SCORE_LIMIT=2. P2 scores twice → GAME_OVER with o_Winner=1 and o_Score_P2=2.
  - Further misses and ticks → no change.
  - i_Game_Start → SERVE, scores 0/0, o_Winner=0.
- Simultaneous and ignored events:
  - Both misses in the same RUNNING cycle → scores unchanged, o_Serve_Dir unchanged, SERVE next cycle.
  - i_Game_Start during RUNNING → ignored.
  - Miss during SERVE → ignored.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for Pong: holds the ball for a serve, runs play,
// scores misses and declares a winner once a player reaches the score limit.
module pong_match_ctrl #(
   parameter int SCORE_WIDTH  = 4,
   parameter int SCORE_LIMIT  = 9,
   parameter int SERVE_FRAMES = 60
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic                   i_Game_Start,
   input  logic                   i_Frame_Tick,
   input  logic                   i_Miss_P1,
   input  logic                   i_Miss_P2,
   output logic [2:0]             o_State,
   output logic                   o_Play_Enable,
   output logic                   o_Ball_Reset,
   output logic                   o_Serve_Dir,
   output logic [SCORE_WIDTH-1:0] o_Score_P1,
   output logic [SCORE_WIDTH-1:0] o_Score_P2,
   output logic                   o_Point,
   output logic                   o_Winner
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      RUNNING   = 3'd2,
      POINT     = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   // A SERVE_FRAMES of 0 is treated as a single-frame hold.
   localparam logic [7:0] SERVE_LAST =
      (SERVE_FRAMES <= 1) ? 8'd0 : 8'(SERVE_FRAMES - 1);
   localparam logic [SCORE_WIDTH-1:0] LIMIT = SCORE_WIDTH'(SCORE_LIMIT);
   localparam logic [SCORE_WIDTH-1:0] ONE   = SCORE_WIDTH'(1);

   state_t     state;
   logic [7:0] frame_cnt;

   assign o_State = state;

   // Match sequencer: state, counters, scores and all registered outputs.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state         <= IDLE;
         frame_cnt     <= 8'd0;
         o_Score_P1    <= '0;
         o_Score_P2    <= '0;
         o_Serve_Dir   <= 1'b1;
         o_Winner      <= 1'b0;
         o_Play_Enable <= 1'b0;
         o_Ball_Reset  <= 1'b1;
         o_Point       <= 1'b0;
      end else begin
         o_Point <= 1'b0;
         case (state)
            IDLE, GAME_OVER: begin
               if (i_Game_Start) begin
                  o_Score_P1  <= '0;
                  o_Score_P2  <= '0;
                  o_Winner    <= 1'b0;
                  o_Serve_Dir <= 1'b1;
                  frame_cnt   <= 8'd0;
                  state       <= SERVE;
               end
            end
            SERVE: begin
               if (i_Frame_Tick) begin
                  if (frame_cnt == SERVE_LAST) begin
                     frame_cnt     <= 8'd0;
                     state         <= RUNNING;
                     o_Play_Enable <= 1'b1;
                     o_Ball_Reset  <= 1'b0;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            RUNNING: begin
               if (i_Miss_P1 && i_Miss_P2) begin
                  state         <= SERVE;
                  o_Play_Enable <= 1'b0;
                  o_Ball_Reset  <= 1'b1;
               end else if (i_Miss_P1) begin
                  o_Score_P2    <= o_Score_P2 + ONE;
                  o_Serve_Dir   <= 1'b0;
                  state         <= POINT;
                  o_Point       <= 1'b1;
                  o_Play_Enable <= 1'b0;
                  o_Ball_Reset  <= 1'b1;
               end else if (i_Miss_P2) begin
                  o_Score_P1    <= o_Score_P1 + ONE;
                  o_Serve_Dir   <= 1'b1;
                  state         <= POINT;
                  o_Point       <= 1'b1;
                  o_Play_Enable <= 1'b0;
                  o_Ball_Reset  <= 1'b1;
               end
            end
            POINT: begin
               // The serve direction points at whoever lost, so it names the scorer.
               if ((o_Serve_Dir && o_Score_P1 == LIMIT) ||
                   (!o_Serve_Dir && o_Score_P2 == LIMIT)) begin
                  o_Winner <= ~o_Serve_Dir;
                  state    <= GAME_OVER;
               end else begin
                  frame_cnt <= 8'd0;
                  state     <= SERVE;
               end
            end
            default: begin
               state         <= IDLE;
               frame_cnt     <= 8'd0;
               o_Play_Enable <= 1'b0;
               o_Ball_Reset  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed test-plan steps followed by
// random pulses, all compared against a rule-level reference model.
module tb_pong_match_ctrl;

   localparam int SW  = 4;
   localparam int LIM = 2;
   localparam int SF  = 3;

   logic          i_Clk = 1'b0;
   logic          i_Rst_L;
   logic          i_Game_Start, i_Frame_Tick, i_Miss_P1, i_Miss_P2;
   logic [2:0]    o_State;
   logic          o_Play_Enable, o_Ball_Reset, o_Serve_Dir, o_Point, o_Winner;
   logic [SW-1:0] o_Score_P1, o_Score_P2;

   int checks = 0;
   int errors = 0;

   // Reference model: match described by phase name, point tallies and tick count.
   int m_phase;
   int m_p1, m_p2, m_ticks, m_last_scorer;
   int m_dir, m_win;

   pong_match_ctrl #(.SCORE_WIDTH(SW), .SCORE_LIMIT(LIM), .SERVE_FRAMES(SF)) dut (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Game_Start(i_Game_Start),
      .i_Frame_Tick(i_Frame_Tick), .i_Miss_P1(i_Miss_P1), .i_Miss_P2(i_Miss_P2),
      .o_State(o_State), .o_Play_Enable(o_Play_Enable), .o_Ball_Reset(o_Ball_Reset),
      .o_Serve_Dir(o_Serve_Dir), .o_Score_P1(o_Score_P1), .o_Score_P2(o_Score_P2),
      .o_Point(o_Point), .o_Winner(o_Winner)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_p1 = 0; m_p2 = 0; m_ticks = 0;
      m_dir = 1; m_win = 0; m_last_scorer = 0;
   endtask

   task automatic new_match();
      m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1; m_ticks = 0; m_phase = 1;
   endtask

   task automatic model_step(input bit st, input bit tk, input bit m1, input bit m2);
      if (m_phase == 0 || m_phase == 4) begin
         if (st) new_match();
      end else if (m_phase == 1) begin
         if (tk) m_ticks++;
         if (m_ticks == SF) begin m_ticks = 0; m_phase = 2; end
      end else if (m_phase == 2) begin
         if (m1 && m2) m_phase = 1;
         else if (m1) begin m_p2++; m_dir = 0; m_last_scorer = 2; m_phase = 3; end
         else if (m2) begin m_p1++; m_dir = 1; m_last_scorer = 1; m_phase = 3; end
      end else begin
         if ((m_last_scorer == 1 ? m_p1 : m_p2) == LIM) begin
            m_win = (m_last_scorer == 2) ? 1 : 0;
            m_phase = 4;
         end else begin
            m_ticks = 0; m_phase = 1;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".state"},  int'(o_State),       m_phase);
      check({tag, ".play"},   int'(o_Play_Enable), (m_phase == 2) ? 1 : 0);
      check({tag, ".ballrst"},int'(o_Ball_Reset),  (m_phase == 2) ? 0 : 1);
      check({tag, ".point"},  int'(o_Point),       (m_phase == 3) ? 1 : 0);
      check({tag, ".dir"},    int'(o_Serve_Dir),   m_dir);
      check({tag, ".p1"},     int'(o_Score_P1),    m_p1);
      check({tag, ".p2"},     int'(o_Score_P2),    m_p2);
      check({tag, ".winner"}, int'(o_Winner),      m_win);
   endtask

   // One clock: drive pulses, clock the DUT and model, check at the falling edge.
   task automatic cycle(input string tag, input bit st, input bit tk, input bit m1, input bit m2);
      i_Game_Start = st; i_Frame_Tick = tk; i_Miss_P1 = m1; i_Miss_P2 = m2;
      @(posedge i_Clk);
      model_step(st, tk, m1, m2);
      @(negedge i_Clk);
      i_Game_Start = 1'b0; i_Frame_Tick = 1'b0; i_Miss_P1 = 1'b0; i_Miss_P2 = 1'b0;
      compare_all(tag);
   endtask

   task automatic serve_out(input string tag);
      for (int k = 0; k < SF; k++) begin
         cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0);
         cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      i_Rst_L = 1'b0;
      i_Game_Start = 1'b0; i_Frame_Tick = 1'b0; i_Miss_P1 = 1'b0; i_Miss_P2 = 1'b0;
      model_reset();
      repeat (2) @(negedge i_Clk);
      compare_all("reset");
      i_Rst_L = 1'b1;

      cycle("idle_tick", 1'b0, 1'b1, 1'b0, 1'b0);
      cycle("idle_miss", 1'b0, 1'b0, 1'b1, 1'b1);
      cycle("idle_miss2", 1'b0, 1'b0, 1'b0, 1'b1);
      check("idle_hold", int'(o_State), 0);

      // Start with a tick on the entry edge, which must not count.
      cycle("start", 1'b1, 1'b1, 1'b0, 1'b0);
      check("start_state", int'(o_State), 1);
      for (int k = 0; k < SF; k++) begin
         repeat (9) cycle("serve_gap", 1'b0, 1'b0, 1'b0, 1'b0);
         check("serve_not_early", int'(o_State), 1);
         cycle("serve_tick", 1'b0, 1'b1, 1'b0, 1'b0);
      end
      check("serve_running", int'(o_State), 2);
      check("serve_play", int'(o_Play_Enable), 1);

      cycle("run_start_ignored", 1'b1, 1'b0, 1'b0, 1'b0);
      check("run_start_state", int'(o_State), 2);

      cycle("miss_p1", 1'b0, 1'b0, 1'b1, 1'b0);
      check("miss_p1_point", int'(o_Point), 1);
      check("miss_p1_score", int'(o_Score_P2), 1);
      check("miss_p1_dir", int'(o_Serve_Dir), 0);
      cycle("after_p1", 1'b0, 1'b0, 1'b0, 1'b0);
      check("after_p1_state", int'(o_State), 1);

      cycle("serve_miss_ignored", 1'b0, 1'b0, 1'b1, 1'b1);
      serve_out("serve2");
      cycle("miss_p2", 1'b0, 1'b0, 1'b0, 1'b1);
      check("miss_p2_score", int'(o_Score_P1), 1);
      check("miss_p2_dir", int'(o_Serve_Dir), 1);
      cycle("after_p2", 1'b0, 1'b0, 1'b0, 1'b0);
      serve_out("serve3");

      cycle("both_miss", 1'b0, 1'b0, 1'b1, 1'b1);
      check("both_state", int'(o_State), 1);
      check("both_p1", int'(o_Score_P1), 1);
      check("both_dir", int'(o_Serve_Dir), 1);
      serve_out("serve4");

      // Asynchronous reset mid-RUNNING with scores 1/1.
      #2 i_Rst_L = 1'b0;
      #1 model_reset();
      compare_all("async_rst");
      check("async_rst_state", int'(o_State), 0);
      #1 i_Rst_L = 1'b1;

      // P2 scores twice to win.
      cycle("m2_start", 1'b1, 1'b0, 1'b0, 1'b0);
      serve_out("m2_serve");
      cycle("m2_miss", 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("m2_point", 1'b0, 1'b0, 1'b0, 1'b0);
      serve_out("m2_serve2");
      cycle("m2_final", 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("m2_over", 1'b0, 1'b0, 1'b0, 1'b0);
      check("gameover_state", int'(o_State), 4);
      check("gameover_winner", int'(o_Winner), 1);
      check("gameover_p2", int'(o_Score_P2), 2);
      cycle("go_ignore", 1'b0, 1'b1, 1'b1, 1'b0);
      cycle("go_ignore2", 1'b0, 1'b1, 1'b0, 1'b1);
      check("go_hold", int'(o_State), 4);
      cycle("go_restart", 1'b1, 1'b0, 1'b0, 1'b0);
      check("restart_state", int'(o_State), 1);
      check("restart_winner", int'(o_Winner), 0);
      check("restart_p2", int'(o_Score_P2), 0);

      for (int n = 0; n < 3000; n++) begin
         cycle("random",
               ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 11) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
